// File: rtl/lc3b_seq_alu.sv
`default_nettype none
// ============================================================================
// Module   : lc3b_seq_alu
// Purpose  : LC-3b style ALU with valid/ready handshake. Logic ops and add
//            complete in one cycle; shifts run one bit per cycle from a
//            down-counter loaded with the shift amount.
// Revision : 1.0  initial release
// ============================================================================
module lc3b_seq_alu #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       nzp,
  output logic             cout,
  output logic             err
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_AND  = 4'd1;
  localparam logic [3:0] OP_NOT  = 4'd2;
  localparam logic [3:0] OP_PASS = 4'd3;
  localparam logic [3:0] OP_SLL  = 4'd4;
  localparam logic [3:0] OP_SRL  = 4'd5;
  localparam logic [3:0] OP_SRA  = 4'd6;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nx;
  logic [SHW-1:0]   cnt;
  logic [3:0]       op_q;

  logic             is_shift;
  logic [SHW-1:0]   amt;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] acc_res;
  logic             acc_cout;
  logic             acc_err;
  logic [WIDTH-1:0] step_res;

  // Condition codes: exactly one bit set, negative takes the sign bit.
  function automatic logic [2:0] nzp_of(input logic [WIDTH-1:0] v);
    if (v == '0)
      nzp_of = 3'b010;
    else if (v[WIDTH-1])
      nzp_of = 3'b100;
    else
      nzp_of = 3'b001;
  endfunction

  assign is_shift = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  assign amt      = b[SHW-1:0];

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // Next-state logic; a zero-amount shift skips SHIFT entirely.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (in_valid)
          state_nx = (is_shift && (amt != '0)) ? SHIFT : DONE;
      end
      SHIFT: begin
        if (cnt <= SHW'(1))
          state_nx = DONE;
      end
      DONE: begin
        if (out_ready)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Handshake outputs decoded straight from the state.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Value loaded on the accept edge; shifts start from the unshifted source.
  always_comb begin
    sum      = {1'b0, a} + {1'b0, b};
    acc_res  = '0;
    acc_cout = 1'b0;
    acc_err  = 1'b0;
    case (op)
      OP_ADD:  {acc_cout, acc_res} = sum;
      OP_AND:  acc_res = a & b;
      OP_NOT:  acc_res = ~a;
      OP_PASS: acc_res = a;
      OP_SLL,
      OP_SRL,
      OP_SRA:  acc_res = a;
      default: acc_err = 1'b1;
    endcase
  end

  // One-bit shift step applied to the working register while in SHIFT.
  always_comb begin
    case (op_q)
      OP_SLL:  step_res = {result[WIDTH-2:0], 1'b0};
      OP_SRL:  step_res = {1'b0, result[WIDTH-1:1]};
      default: step_res = {result[WIDTH-1], result[WIDTH-1:1]};
    endcase
  end

  // Datapath: capture on accept, step during SHIFT, hold otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      op_q   <= '0;
      result <= '0;
      nzp    <= 3'b000;
      cout   <= 1'b0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q   <= op;
            cnt    <= is_shift ? amt : '0;
            result <= acc_res;
            nzp    <= nzp_of(acc_res);
            cout   <= acc_cout;
            err    <= acc_err;
          end
        end
        SHIFT: begin
          cnt    <= cnt - SHW'(1);
          result <= step_res;
          nzp    <= nzp_of(step_res);
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire
